uart_ram_host: RTL and testbench
================================

// Module: uart_ram_host
// PURPOSE
//  Host-side initiator for the UART RAM-access protocol: turns write/read requests into command
//  frames (write: F0,addr,data; read: 0F,addr). Drives a UART TX byte interface. For reads, waits for
//  the single reply byte on a UART RX byte interface, with a timeout. Sits between a local
//  requester (CPU/test sequencer) and uart_tx/uart_rx of a link to the RAM-side board.
// PARAMETERS
//  CMD_WR       8'hF0     write command byte
//  CMD_RD       8'h0F     read command byte
//  TIMEOUT_CYC  50000     sys_clk cycles to wait for a read reply (>=2)
//  TO_W         16        timeout counter width; 2**TO_W > TIMEOUT_CYC
// PORTS
//  sys_clk      in   1   system clock; one clock; reset is synchronous and active-high
//  rst          in   1   synchronous active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept; high only in IDLE
//  req_write    in   1   1=write, 0=read
//  req_addr     in   8   RAM address
//  req_wdata    in   8   write data (ignored for reads)
//  rsp_valid    out  1   one-cycle completion pulse (write and read)
//  rsp_rdata    out  8   read data; 8'h00 for writes and timeouts; held until next rsp_valid
//  rsp_timeout  out  1   qualifies rsp_valid: read reply not received
//  tx_start     out  1   one-cycle pulse: send tx_data
//  tx_data      out  8   byte to send; stable from tx_start until tx_busy falls
//  tx_busy      in   1   UART TX busy; must rise within 1 cycle after tx_start
//  rx_valid     in   1   one-cycle pulse: rx_data holds a received byte
//  rx_data      in   8   received byte
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, tx_start=0, tx_data=0.
//  Accept on req_valid&req_ready at edge N; req_write/addr/wdata latched; req_ready=0 from N+1.
//  FSM (all outputs registered):
//   IDLE  : accept -> LOAD, byte_idx=0
//   LOAD  : if !tx_busy: tx_start=1 for one cycle, tx_data=frame[byte_idx] -> ACK; else stay
//   ACK   : wait tx_busy=1 -> DRAIN
//   DRAIN : wait tx_busy=0; last byte (idx 2 wr / idx 1 rd) -> DONE (wr) or RESP (rd);
//           else byte_idx++ -> LOAD
//   RESP  : timer cleared on entry, +1 per cycle; rx_valid -> rsp_rdata=rx_data, DONE;
//           timer==TIMEOUT_CYC-1 without rx_valid -> rsp_timeout=1, rsp_rdata=0, DONE
//   DONE  : rsp_valid=1 for exactly one cycle -> IDLE (req_ready=1 next cycle)
//  Frame: wr = {CMD_WR, addr, wdata}; rd = {CMD_RD, addr}.
//  First tx_start: N+2 when tx_busy=0 at accept (LOAD is one cycle).
//  rx_valid outside RESP: ignored, dropped (stale/echo bytes never complete a request).
//  rx_valid on the same cycle the timer expires: data wins, rsp_timeout=0.
//  Second rx_valid in RESP impossible: first one leaves RESP.
//  tx_busy already high in LOAD: no pulse until it falls.
//  rsp_timeout cleared on next accept.
//  rst mid-frame: IDLE next edge, tx_start low, no rsp_valid. Byte already in UART completes
//  (UART-owned). Far end then sees a truncated frame and resyncs on its next command.
//  Back-to-back: new request accepted the cycle after rsp_valid; no bytes interleave.
// STRUCTURE
//  Package uart_ram_pkg: CMD_WR/CMD_RD constants, state encoding (IDLE..DONE), frame length consts.
//  Sub-module uart_ram_rsp_timer (TO_W counter: clear, enable, expire==TIMEOUT_CYC-1).
//  FSM, frame mux and byte_idx stay in the top.
// TESTING (UART model: tx_busy high 10 cycles after each tx_start)
//  Write a=0x12 d=0xA5 -> TX bytes F0,12,A5 in order; one rsp_valid; rsp_timeout=0; rsp_rdata=00
//  Read a=0x34, model replies 0x5C 20 cycles after last byte -> TX 0F,34; rsp_rdata=5C; timeout=0
//  Read, no reply (TIMEOUT_CYC=100) -> rsp_valid exactly 100 cycles after RESP entry, rsp_timeout=1
//  rx_valid=0x77 during write frame, then read reply 0x3C -> rsp_rdata=3C (0x77 dropped)
//  rst pulse after second byte of write -> no 3rd tx_start; no rsp_valid; req_ready=1 next cycle
//  Reply arrives on timer's last cycle -> rsp_rdata=data, rsp_timeout=0; req_valid held
//  continuously -> next request accepted cycle after rsp_valid

Source files
------------

// File: rtl/uart_ram_pkg.sv
// Shared constants, state encoding and frame helpers for the UART RAM-access host.
package uart_ram_pkg;

  localparam logic [7:0] CMD_WR_DEFAULT = 8'hF0;
  localparam logic [7:0] CMD_RD_DEFAULT = 8'h0F;

  // Frame lengths in bytes: write = cmd,addr,data; read = cmd,addr.
  localparam int FRAME_LEN_WR = 3;
  localparam int FRAME_LEN_RD = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACK   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Index of the final byte of the frame for the given request type.
  function automatic logic [1:0] last_idx(input logic write);
    return write ? 2'(FRAME_LEN_WR - 1) : 2'(FRAME_LEN_RD - 1);
  endfunction

  // Byte at position idx of the command frame.
  function automatic logic [7:0] frame_byte(input logic       write,
                                            input logic [1:0] idx,
                                            input logic [7:0] cmd_wr,
                                            input logic [7:0] cmd_rd,
                                            input logic [7:0] addr,
                                            input logic [7:0] wdata);
    case (idx)
      2'd0:    return write ? cmd_wr : cmd_rd;
      2'd1:    return addr;
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/uart_ram_rsp_timer.sv
// Read-reply timeout counter: cleared while idle, counts while enabled,
// flags the last allowed cycle of the reply window.
module uart_ram_rsp_timer
  import uart_ram_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int TO_W        = 16
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] count;

  // Count enabled cycles; clear has priority so the window restarts at zero.
  always_ff @(posedge sys_clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TO_W'(1);
    end
  end

  assign expire = enable && (count == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_ram_host.sv
// Host-side initiator: serialises write/read requests into command frames on a
// UART TX byte interface and collects the single read reply from UART RX.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// LOAD  | waiting for tx_busy low, then pulse tx_start with the current byte
// ACK   | waiting for the UART to raise tx_busy
// DRAIN | waiting for tx_busy low; advance byte or finish the frame
// RESP  | read only: waiting for the reply byte or the timeout
// DONE  | rsp_valid high for this single cycle
module uart_ram_host
  import uart_ram_pkg::*;
#(
  parameter logic [7:0] CMD_WR      = CMD_WR_DEFAULT,
  parameter logic [7:0] CMD_RD      = CMD_RD_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  state_t     state;
  logic       lat_write;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [1:0] byte_idx;
  logic [7:0] cur_byte;
  logic       timer_expire;

  assign cur_byte = frame_byte(lat_write, byte_idx, CMD_WR, CMD_RD, lat_addr, lat_wdata);

  // Timer sits at zero outside RESP, so it always starts the window from zero.
  uart_ram_rsp_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_rsp_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear   (state != ST_RESP),
    .enable  (state == ST_RESP),
    .expire  (timer_expire)
  );

  // Request sequencing FSM with registered handshake and UART outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_timeout <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      byte_idx    <= 2'd0;
      lat_write   <= 1'b0;
      lat_addr    <= 8'h00;
      lat_wdata   <= 8'h00;
    end else begin
      tx_start  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lat_write   <= req_write;
            lat_addr    <= req_addr;
            lat_wdata   <= req_wdata;
            byte_idx    <= 2'd0;
            rsp_timeout <= 1'b0;
            req_ready   <= 1'b0;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= cur_byte;
            state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (tx_busy) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            if (byte_idx == last_idx(lat_write)) begin
              if (lat_write) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= 8'h00;
                state     <= ST_DONE;
              end else begin
                state <= ST_RESP;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= ST_LOAD;
            end
          end
        end
        ST_RESP: begin
          // A reply on the expiry cycle still counts as a reply.
          if (rx_valid) begin
            rsp_rdata <= rx_data;
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (timer_expire) begin
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ram_host.sv
// Directed bench for uart_ram_host with a UART TX busy model and a
// scoreboard of expected TX bytes and responses.
module tb_uart_ram_host;

  localparam int TO = 100;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int tx_count = 0;
  int fall_count = 0;
  int fall_cyc = 0;
  logic prev_start = 1'b0;
  logic prev_rsp = 1'b0;
  logic prev_busy = 1'b0;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rsp[$];

  uart_ram_host #(
    .TIMEOUT_CYC (TO),
    .TO_W        (16)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // UART TX model: busy for 10 cycles after each tx_start, independent of rst.
  always @(posedge sys_clk) begin
    if (tx_start) begin
      busy_cnt <= 10;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (tx_start) begin
      tx_count++;
      chk("tx_start_one_cycle", 32'(prev_start), 32'h0);
      chk("tx_start_while_busy", 32'(prev_busy), 32'h0);
      checks++;
      assert (exp_tx.size() > 0) else begin
        errors++;
        $error("FAIL tx_unexpected: observed %h expected none", tx_data);
      end
      if (exp_tx.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    if (rsp_valid) begin
      chk("rsp_one_cycle", 32'(prev_rsp), 32'h0);
      checks++;
      assert (exp_rsp.size() > 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed %h expected none", {rsp_timeout, rsp_rdata});
      end
      if (exp_rsp.size() > 0) chk("rsp_timeout_rdata", 32'({rsp_timeout, rsp_rdata}),
                                  32'(exp_rsp.pop_front()));
    end
    if (prev_busy && !tx_busy) begin
      fall_count++;
      fall_cyc = cyc;
    end
    prev_start = tx_start;
    prev_rsp   = rsp_valid;
    prev_busy  = tx_busy;
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic push_frame(input logic wr, input logic [7:0] a, input logic [7:0] d);
    exp_tx.push_back(wr ? 8'hF0 : 8'h0F);
    exp_tx.push_back(a);
    if (wr) exp_tx.push_back(d);
  endtask

  // Present a request and return at the falling edge just after it is accepted.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d, input bit hold);
    int n = 0;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    assert (req_ready === 1'b1) else begin
      errors++;
      $error("FAIL accept_wait: observed req_ready %b expected 1", req_ready);
    end
    push_frame(wr, a, d);
    tick();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at_cyc);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    at_cyc = cyc;
    checks++;
    assert (rsp_valid === 1'b1) else begin
      errors++;
      $error("FAIL rsp_wait: observed no rsp_valid within %0d cycles expected one", n);
    end
  endtask

  // Wait until the tx_target-th byte has been started and its busy has fallen.
  task automatic wait_last_fall(input int tx_target);
    int n = 0;
    int fb;
    while (tx_count < tx_target && n < 500) begin
      tick();
      n++;
    end
    fb = fall_count;
    while (fall_count <= fb && n < 500) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 500) else begin
      errors++;
      $error("FAIL frame_wait: observed %0d cycles expected below 500", n);
    end
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed time limit expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int tb;
    int f;
    int n_start;
    int n_rsp;

    // Reset state.
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    rst = 1'b0;
    tick();

    // Write 0x12 <- 0xA5; first tx_start two edges after acceptance.
    exp_rsp.push_back({1'b0, 8'h00});
    issue(1'b1, 8'h12, 8'hA5, 1'b0);
    chk("req_ready_low_after_accept", 32'(req_ready), 32'h0);
    tick();
    chk("first_tx_start_latency", 32'(tx_start), 32'h1);
    wait_rsp(t);
    tick();
    chk("req_ready_after_done", 32'(req_ready), 32'h1);

    // Read 0x34, reply 0x5C twenty cycles after the last byte.
    exp_rsp.push_back({1'b0, 8'h5C});
    tb = tx_count;
    issue(1'b0, 8'h34, 8'h00, 1'b0);
    wait_last_fall(tb + 2);
    while (cyc < fall_cyc + 20) tick();
    rx_data  = 8'h5C;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    wait_rsp(t);
    tick();

    // Read 0x56 with no reply: timeout 100 cycles after RESP entry.
    exp_rsp.push_back({1'b1, 8'h00});
    tb = tx_count;
    issue(1'b0, 8'h56, 8'h00, 1'b0);
    chk("rdata_held_after_read", 32'(rsp_rdata), 32'h5C);
    wait_last_fall(tb + 2);
    f = fall_cyc;
    wait_rsp(t);
    chk("timeout_latency", 32'(t - (f + 1)), 32'd100);
    tick();
    chk("timeout_flag_held", 32'(rsp_timeout), 32'h1);

    // Stray rx byte during a write is dropped; later read gets its own reply.
    exp_rsp.push_back({1'b0, 8'h00});
    tb = tx_count;
    issue(1'b1, 8'h20, 8'h11, 1'b0);
    chk("timeout_cleared_on_accept", 32'(rsp_timeout), 32'h0);
    while (tx_count < tb + 1) tick();
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    wait_rsp(t);
    tick();
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    exp_rsp.push_back({1'b0, 8'h3C});
    tb = tx_count;
    issue(1'b0, 8'h21, 8'h00, 1'b0);
    wait_last_fall(tb + 2);
    while (cyc < fall_cyc + 5) tick();
    rx_data  = 8'h3C;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    wait_rsp(t);
    tick();

    // Reset during the second byte of a write: frame abandoned, no response.
    tb = tx_count;
    issue(1'b1, 8'h30, 8'hC3, 1'b0);
    while (tx_count < tb + 2) tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_tx.pop_back());
    chk("rst_mid_req_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_tx_start", 32'(tx_start), 32'h0);
    chk("rst_mid_busy_still_high", 32'(tx_busy), 32'h1);
    n_start = 0;
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_start) n_start++;
      if (rsp_valid) n_rsp++;
    end
    chk("rst_mid_no_tx_start", 32'(n_start), 32'h0);
    chk("rst_mid_no_rsp", 32'(n_rsp), 32'h0);

    // Read issued while the UART is still busy; reply on the timer's last
    // cycle; req_valid held so the next write follows back-to-back.
    exp_rsp.push_back({1'b0, 8'h9E});
    tb = tx_count;
    issue(1'b0, 8'h40, 8'h00, 1'b1);
    req_write = 1'b1;
    req_addr  = 8'h41;
    req_wdata = 8'h66;
    push_frame(1'b1, 8'h41, 8'h66);
    exp_rsp.push_back({1'b0, 8'h00});
    wait_last_fall(tb + 2);
    while (cyc < fall_cyc + 100) tick();
    rx_data  = 8'h9E;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("last_cycle_reply_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("last_cycle_reply_timeout", 32'(rsp_timeout), 32'h0);
    tick();
    chk("b2b_ready_after_rsp", 32'(req_ready), 32'h1);
    tick();
    chk("b2b_accepted", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    tick();
    chk("b2b_first_tx_start", 32'(tx_start), 32'h1);
    wait_rsp(t);
    tick();
    tick();

    chk("tx_queue_drained", 32'(exp_tx.size()), 32'h0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
